// File: rtl/dmx_ebr_arbiter.sv
// dmx_ebr_arbiter: shares the DMX Tx dimming EBR between Tx slot reads, posted host writes and host read-back.
module dmx_ebr_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 8,
    parameter int WFIFO_DEPTH = 4,
    parameter int MAX_SLOT    = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_req,
    input  logic [ADDR_W-1:0] tx_addr,
    output logic              tx_gnt,
    output logic [DATA_W-1:0] tx_rdata,
    output logic              tx_rvalid,
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [ADDR_W-1:0] host_wr_addr,
    input  logic [DATA_W-1:0] host_wr_data,
    output logic              host_wr_err,
    input  logic              host_rd_req,
    input  logic [ADDR_W-1:0] host_rd_addr,
    output logic              host_rd_gnt,
    output logic [DATA_W-1:0] host_rd_data,
    output logic              host_rd_valid,
    output logic [2:0]        wfifo_level,
    output logic              ebr_ce,
    output logic              ebr_we,
    output logic [ADDR_W-1:0] ebr_addr,
    output logic [DATA_W-1:0] ebr_wdata,
    input  logic [DATA_W-1:0] ebr_q
);
    localparam int PW = $clog2(WFIFO_DEPTH) + 1;
    typedef enum logic [1:0] {TAG_NONE, TAG_TX, TAG_HOST} tag_t;
    logic [ADDR_W+DATA_W-1:0] mem [WFIFO_DEPTH];
    logic [PW-1:0] wp, rp, lvl;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic full, empty, bad, push, store, pop;
    logic t_req, w_req, r_req, host_first, gt, gw, gr, starve;
    tag_t tag1, tag2;
    assign lvl = wp - rp;
    assign empty = wp == rp;
    assign full = (wp[PW-1] != rp[PW-1]) && (wp[PW-2:0] == rp[PW-2:0]);
    assign host_wr_ready = !full;
    assign wfifo_level = 3'(lvl);
    assign bad = host_wr_addr > ADDR_W'(MAX_SLOT);
    assign push = host_wr_valid && !full && !bad;
    // An empty FIFO forwards the incoming push so a lone write reaches the EBR next cycle.
    assign {head_addr, head_data} = empty ? {host_wr_addr, host_wr_data} : mem[rp[PW-2:0]];
    assign store = push && !(gw && empty);
    assign pop = gw && !empty;
    assign t_req = tx_req && !tx_gnt;
    assign w_req = !empty || push;
    assign r_req = host_rd_req && !host_rd_gnt && empty;
    always_comb begin
        host_first = starve || !t_req;
        gw = w_req && host_first;
        gr = r_req && !w_req && host_first;
        gt = t_req && !gw && !gr;
    end
    always_ff @(posedge clk)
        if (store)
            mem[wp[PW-2:0]] <= {host_wr_addr, host_wr_data};
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            starve <= 1'b0;
            tag1 <= TAG_NONE;
            tag2 <= TAG_NONE;
            tx_gnt <= 1'b0;
            tx_rvalid <= 1'b0;
            tx_rdata <= '0;
            host_rd_gnt <= 1'b0;
            host_rd_valid <= 1'b0;
            host_rd_data <= '0;
            host_wr_err <= 1'b0;
            ebr_ce <= 1'b0;
            ebr_we <= 1'b0;
            ebr_addr <= '0;
            ebr_wdata <= '0;
        end else begin
            wp <= wp + PW'(store);
            rp <= rp + PW'(pop);
            starve <= (gw || gr) ? 1'b0 : (w_req || r_req) ? 1'b1 : starve;
            tx_gnt <= gt;
            host_rd_gnt <= gr;
            host_wr_err <= host_wr_valid && !full && bad;
            ebr_ce <= gt || gw || gr;
            ebr_we <= gw;
            if (gt || gw || gr)
                ebr_addr <= gt ? tx_addr : gw ? head_addr : host_rd_addr;
            if (gw)
                ebr_wdata <= head_data;
            tag1 <= gt ? TAG_TX : gr ? TAG_HOST : TAG_NONE;
            tag2 <= tag1;
            tx_rvalid <= tag2 == TAG_TX;
            host_rd_valid <= tag2 == TAG_HOST;
            if (tag2 == TAG_TX)
                tx_rdata <= ebr_q;
            if (tag2 == TAG_HOST)
                host_rd_data <= ebr_q;
        end
    end
endmodule

// File: tb/tb_dmx_ebr_arbiter.sv
// tb_dmx_ebr_arbiter: directed bench with a behavioural single-port EBR and a log of every EBR write.
module tb_dmx_ebr_arbiter;
    logic clk, rst;
    logic tx_req, tx_gnt, tx_rvalid;
    logic [9:0] tx_addr;
    logic [7:0] tx_rdata;
    logic host_wr_valid, host_wr_ready, host_wr_err;
    logic [9:0] host_wr_addr;
    logic [7:0] host_wr_data;
    logic host_rd_req, host_rd_gnt, host_rd_valid;
    logic [9:0] host_rd_addr;
    logic [7:0] host_rd_data;
    logic [2:0] wfifo_level;
    logic ebr_ce, ebr_we;
    logic [9:0] ebr_addr;
    logic [7:0] ebr_wdata, ebr_q;
    logic [7:0] ebr [1024];
    logic [9:0] log_a [$];
    logic [7:0] log_d [$];
    int n_tests = 0, n_fail = 0;

    dmx_ebr_arbiter dut (
        .clk(clk), .rst(rst),
        .tx_req(tx_req), .tx_addr(tx_addr), .tx_gnt(tx_gnt), .tx_rdata(tx_rdata), .tx_rvalid(tx_rvalid),
        .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_addr(host_wr_addr),
        .host_wr_data(host_wr_data), .host_wr_err(host_wr_err),
        .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr), .host_rd_gnt(host_rd_gnt),
        .host_rd_data(host_rd_data), .host_rd_valid(host_rd_valid),
        .wfifo_level(wfifo_level),
        .ebr_ce(ebr_ce), .ebr_we(ebr_we), .ebr_addr(ebr_addr), .ebr_wdata(ebr_wdata), .ebr_q(ebr_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (ebr_ce) begin
            if (ebr_we) begin
                ebr[ebr_addr] <= ebr_wdata;
                log_a.push_back(ebr_addr);
                log_d.push_back(ebr_wdata);
            end else
                ebr_q <= ebr[ebr_addr];
        end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int base, lv, bad513;
        for (int i = 0; i < 1024; i++) ebr[i] = 8'h00;
        ebr[5] = 8'hA7;
        ebr[7] = 8'h5A;
        ebr_q = 8'h00;
        rst = 1; tx_req = 0; tx_addr = 0; host_wr_valid = 0; host_wr_addr = 0; host_wr_data = 0;
        host_rd_req = 0; host_rd_addr = 0;
        tick; tick;
        chk("rst_tx_gnt", tx_gnt, 0);
        chk("rst_ce", ebr_ce, 0);
        chk("rst_we", ebr_we, 0);
        chk("rst_tx_rdata", tx_rdata, 0);
        chk("rst_ebr_addr", ebr_addr, 0);
        chk("rst_ready", host_wr_ready, 1);
        chk("rst_level", wfifo_level, 0);
        rst = 0;
        tick;

        // Tx only, request held through its grant cycle
        tx_req = 1; tx_addr = 5;
        tick;
        chk("tx_gnt", tx_gnt, 1);
        chk("tx_ce", ebr_ce, 1);
        chk("tx_addr", ebr_addr, 5);
        chk("tx_we", ebr_we, 0);
        tick;
        chk("tx_gnt_once", tx_gnt, 0);
        chk("tx_ce_once", ebr_ce, 0);
        chk("tx_rvalid_early", tx_rvalid, 0);
        tx_req = 0;
        tick;
        chk("tx_rvalid", tx_rvalid, 1);
        chk("tx_rdata", tx_rdata, 8'hA7);
        tick;
        chk("tx_rvalid_pulse", tx_rvalid, 0);

        // Posted writes with no Tx traffic
        for (int i = 1; i <= 5; i++) begin
            host_wr_valid = 1; host_wr_addr = 10'(i); host_wr_data = 8'(8'h11 * i);
            tick;
            chk("pw_we", ebr_we, 1);
            chk("pw_addr", ebr_addr, i);
            chk("pw_wdata", ebr_wdata, 8'(8'h11 * i));
            chk("pw_level", wfifo_level, 0);
        end
        host_wr_valid = 0;
        tick;
        chk("pw_idle_we", ebr_we, 0);
        chk("pw_level_end", wfifo_level, 0);

        // Tx held continuously against a stream of host writes: grants alternate, FIFO fills
        base = log_a.size();
        tx_req = 1; tx_addr = 7;
        host_wr_valid = 1; host_wr_addr = 30; host_wr_data = 8'h40;
        tick;
        for (int k = 1; k <= 8; k++) begin
            lv = (k <= 7) ? (k + 1) / 2 : 3;
            chk("ct_tx_gnt", tx_gnt, k % 2);
            chk("ct_we", ebr_we, 1 - k % 2);
            chk("ct_addr", ebr_addr, (k % 2) ? 7 : 29 + k / 2);
            chk("ct_level", wfifo_level, lv);
            chk("ct_ready", host_wr_ready, lv < 4);
            if (k <= 7) begin
                host_wr_addr = 10'(30 + k); host_wr_data = 8'(8'h40 + k);
            end else begin
                host_wr_valid = 0; tx_req = 0;
            end
            tick;
        end
        for (int i = 0; i < 20 && wfifo_level != 0; i++) tick;
        chk("ct_drained", wfifo_level, 0);
        tick; tick; tick;
        chk("ct_log_n", log_a.size() - base, 7);
        for (int i = 0; i < 7; i++) begin
            chk("ct_log_addr", (base + i < log_a.size()) ? log_a[base + i] : 10'h3FF, 30 + i);
            chk("ct_log_data", (base + i < log_d.size()) ? log_d[base + i] : 8'hFF, 8'h40 + i);
        end

        // Read-after-write ordering: the read waits behind the posted write
        tx_req = 1; tx_addr = 7;
        host_wr_valid = 1; host_wr_addr = 9; host_wr_data = 8'h3C;
        tick;
        chk("ord_tx_gnt", tx_gnt, 1);
        chk("ord_level", wfifo_level, 1);
        tx_req = 0; host_wr_valid = 0;
        host_rd_req = 1; host_rd_addr = 9;
        tick;
        chk("ord_rd_gnt_wait", host_rd_gnt, 0);
        chk("ord_we", ebr_we, 1);
        chk("ord_we_addr", ebr_addr, 9);
        tick;
        chk("ord_rd_gnt", host_rd_gnt, 1);
        chk("ord_rd_ce", ebr_ce, 1);
        chk("ord_rd_we", ebr_we, 0);
        chk("ord_rd_addr", ebr_addr, 9);
        chk("ord_tx_rvalid", tx_rvalid, 1);
        chk("ord_tx_rdata", tx_rdata, 8'h5A);
        host_rd_req = 0;
        tick;
        chk("ord_rd_gnt_once", host_rd_gnt, 0);
        chk("ord_rd_valid_early", host_rd_valid, 0);
        tick;
        chk("ord_rd_valid", host_rd_valid, 1);
        chk("ord_rd_data", host_rd_data, 8'h3C);
        tick;

        // Range check: 513 is dropped with an error pulse, 512 is accepted
        host_wr_valid = 1; host_wr_addr = 513; host_wr_data = 8'hEE;
        tick;
        chk("rng_err", host_wr_err, 1);
        chk("rng_we_513", ebr_we, 0);
        chk("rng_level", wfifo_level, 0);
        host_wr_addr = 512; host_wr_data = 8'h99;
        tick;
        chk("rng_err_once", host_wr_err, 0);
        chk("rng_we_512", ebr_we, 1);
        chk("rng_addr_512", ebr_addr, 512);
        chk("rng_wdata_512", ebr_wdata, 8'h99);
        host_wr_valid = 0;
        tick;

        // Reset the cycle after a Tx grant while a write is queued
        tx_req = 1; tx_addr = 5;
        host_wr_valid = 1; host_wr_addr = 40; host_wr_data = 8'h40;
        tick;
        chk("rr_tx_gnt", tx_gnt, 1);
        tx_req = 0; host_wr_addr = 41; host_wr_data = 8'h41;
        tick;
        chk("rr_level", wfifo_level, 1);
        host_wr_valid = 0; rst = 1;
        tick;
        chk("rr_tx_gnt0", tx_gnt, 0);
        chk("rr_tx_rvalid", tx_rvalid, 0);
        chk("rr_tx_rdata", tx_rdata, 0);
        chk("rr_rd_data", host_rd_data, 0);
        chk("rr_rd_valid", host_rd_valid, 0);
        chk("rr_err", host_wr_err, 0);
        chk("rr_ce", ebr_ce, 0);
        chk("rr_we", ebr_we, 0);
        chk("rr_ebr_addr", ebr_addr, 0);
        chk("rr_ebr_wdata", ebr_wdata, 0);
        chk("rr_level0", wfifo_level, 0);
        chk("rr_ready", host_wr_ready, 1);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("rr_no_rvalid", tx_rvalid, 0);
            chk("rr_no_access", ebr_ce, 0);
        end

        bad513 = 0;
        foreach (log_a[i]) if (log_a[i] == 10'd513) bad513++;
        chk("no_write_513", bad513, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
